// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 constants, state encoding and bit-mixing functions.
package sha256_pkg;
  typedef enum logic [1:0] {IDLE, BLK0, BLK1, DONE} state_t;
  typedef logic [0:7][31:0] st_t;
  localparam st_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] ch(input logic [31:0] x, y, z);
    return (x & y) ^ (~x & z);
  endfunction
  function automatic logic [31:0] maj(input logic [31:0] x, y, z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction
  // next schedule word from W[t], W[t+1], W[t+9], W[t+14]
  function automatic logic [31:0] sched(input logic [31:0] w0, w1, w9, w14);
    return ssig1(w14) + w9 + ssig0(w1) + w0;
  endfunction
endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round; s/n hold a..h with a at index 0.
module sha256_round
  import sha256_pkg::*;
(
  input  st_t         s,
  input  logic [31:0] w,
  input  logic [31:0] k,
  output st_t         n
);
  logic [31:0] t1, t2;
  assign t1 = s[7] + bsig1(s[4]) + ch(s[4], s[5], s[6]) + k + w;
  assign t2 = bsig0(s[0]) + maj(s[0], s[1], s[2]);
  assign n  = {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
endmodule

// File: rtl/sha256_1024in.sv
// sha256_1024in: two-block SHA-256 core for pre-padded 1024-bit messages, 64 rounds + 1 feed-forward per block.
// SHA256_2ROUND_EN: two chained rounds per cycle (32 + 1 cycles per block).
module sha256_1024in
  import sha256_pkg::*;
(
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          in_valid,
  input  logic [1023:0] in,
  output logic          in_ready,
  output logic          out_valid,
  output logic [255:0]  out,
  input  logic          out_ready
);
  state_t state, nxt;
  st_t v, vn, hr, hs;
  logic [0:15][31:0] w, wn, blk1;
  logic [6:0] cnt;
  logic acc, ff, busy;
  assign in_ready  = state == IDLE || state == DONE;
  assign out_valid = state == DONE;
  assign acc  = in_valid && in_ready;
  assign busy = state == BLK0 || state == BLK1;
  assign ff   = cnt == 7'd64;
  for (genvar i = 0; i < 8; i++) begin : g_ff
    assign hs[i] = hr[i] + v[i];
  end
`ifdef SHA256_2ROUND_EN
  localparam logic [6:0] step = 7'd2;
  st_t v1;
  sha256_round u_r0 (.s(v), .w(w[0]), .k(K[cnt[5:0]]), .n(v1));
  sha256_round u_r1 (.s(v1), .w(w[1]), .k(K[cnt[5:0] + 6'd1]), .n(vn));
  assign wn = {w[2:15], sched(w[0], w[1], w[9], w[14]), sched(w[1], w[2], w[10], w[15])};
`else
  localparam logic [6:0] step = 7'd1;
  sha256_round u_r0 (.s(v), .w(w[0]), .k(K[cnt[5:0]]), .n(vn));
  assign wn = {w[1:15], sched(w[0], w[1], w[9], w[14])};
`endif
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (acc) nxt = BLK0;
    else if (state == BLK0 && ff) nxt = BLK1;
    else if (state == BLK1 && ff) nxt = DONE;
    else if (state == DONE && out_ready) nxt = IDLE;
  end
  // cnt==64 is the feed-forward cycle: fold into H and restart rounds on the next block
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      cnt  <= '0;
      v    <= '0;
      hr   <= '0;
      w    <= '0;
      blk1 <= '0;
      out  <= '0;
    end else if (acc) begin
      cnt  <= '0;
      v    <= IV;
      hr   <= IV;
      w    <= in[1023:512];
      blk1 <= in[511:0];
    end else if (busy) begin
      cnt <= ff ? 7'd0 : cnt + step;
      v   <= ff ? hs : vn;
      hr  <= ff ? hs : hr;
      w   <= ff ? blk1 : wn;
      if (ff && state == BLK1) out <= hs;
    end
endmodule

// File: tb/tb_sha256_1024in.sv
// tb_sha256_1024in: directed vectors with known SHA-256 digests, handshake and reset checks.
module tb_sha256_1024in;
`ifdef SHA256_2ROUND_EN
  localparam int LAT = 66;
`else
  localparam int LAT = 130;
`endif
  localparam logic [1023:0] V1 = {"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq",
                                  8'h80, 504'h0, 64'd448};
  localparam logic [1023:0] V2 = {"abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmnhijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu",
                                  8'h80, 56'h0, 64'd896};
  localparam logic [255:0] D1 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D2 = 256'hcf5b16a778af8380036ce59e7b0492370b249b11e8f07a51afac45037afee9d1;
  logic clk_i = 1'b0, rst_i = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [1023:0] msg = '0;
  logic [255:0] dig, dig0;
  int n_cmp = 0, n_err = 0;
  sha256_1024in dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid(in_valid), .in(msg),
    .in_ready(in_ready), .out_valid(out_valid), .out(dig), .out_ready(out_ready));
  always #5 clk_i = ~clk_i;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask
  // accept v (with out_ready=ordy on that edge), poke in_valid/in while busy, then check the digest
  task automatic run(input logic [1023:0] v, input logic [255:0] d, input logic ordy, input string tag);
    int busy_rdy = 0;
    msg = v;
    in_valid = 1'b1;
    out_ready = ordy;
    tick;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk({tag, "_ovdrop"}, out_valid, 0);
    for (int i = 1; i < LAT; i++) begin
      busy_rdy += int'(in_ready);
      in_valid = (i < 40) ? i[0] : 1'b0;
      msg = (i < 40) ? ~v : '0;
      tick;
    end
    chk({tag, "_busy_rdy"}, busy_rdy, 0);
    chk({tag, "_early"}, out_valid, 0);
    tick;
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_digest"}, dig, d);
    chk({tag, "_rdy"}, in_ready, 1);
  endtask
  initial begin
    int bad = 0;
    #3 rst_i = 1'b0;
    tick;
    tick;
    chk("rst_rdy", in_ready, 1);
    chk("rst_ov", out_valid, 0);
    chk("rst_out", dig, 0);
    rst_i = 1'b1;
    tick;
    run(V1, D1, 1'b0, "t1");
    dig0 = dig;
    for (int i = 0; i < 20; i++) begin
      tick;
      bad += int'(out_valid !== 1'b1 || dig !== dig0);
    end
    chk("bp_stable", bad, 0);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("cons_ov", out_valid, 0);
    chk("cons_rdy", in_ready, 1);
    chk("cons_hold", dig, D1);
    run(V1, D1, 1'b0, "t3");
    run(V2, D2, 1'b0, "chain");
    run(V1, D1, 1'b1, "win");
    msg = V2;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (69) tick;
    #2 rst_i = 1'b0;
    #1;
    chk("arst_rdy", in_ready, 1);
    chk("arst_ov", out_valid, 0);
    chk("arst_out", dig, 0);
    tick;
    rst_i = 1'b1;
    tick;
    run(V1, D1, 1'b0, "rerun");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
